// File: rtl/traffic_light_pkg.sv
// Phase encoding and lamp decode helpers shared by the traffic-light
// controller and its monitor.
package traffic_light_pkg;

    localparam logic [1:0] PH_RED    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;
    localparam logic [1:0] PH_NONE   = 2'b11;

    typedef enum logic {
        MON_ACQUIRE = 1'b0,
        MON_TRACK   = 1'b1
    } mon_state_t;

    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_RED:    nxt = PH_GREEN;
            PH_GREEN:  nxt = PH_YELLOW;
            PH_YELLOW: nxt = PH_RED;
            default:   nxt = PH_NONE;
        endcase
        return nxt;
    endfunction

    // Exactly one lamp lit maps to a phase; anything else is NONE.
    function automatic logic [1:0] lamp_to_phase(input logic [2:0] lamp_ryg);
        logic [1:0] ph;
        case (lamp_ryg)
            3'b100:  ph = PH_RED;
            3'b001:  ph = PH_GREEN;
            3'b010:  ph = PH_YELLOW;
            default: ph = PH_NONE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/traffic_light_run_counter.sv
// Counts how long the current lamp vector has been held; reloads 1 on a change
// and flags the edge on which the count would step past the phase limit.
module traffic_light_run_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             change,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] run,
    output logic             eq_limit_plus1
);

    localparam logic [CNT_W-1:0] RUN_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == RUN_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= '0;
        end else if (change) begin
            run <= CNT_W'(1);
        end else begin
            run <= sat_inc(run);
        end
    end

    assign eq_limit_plus1 = !change && (run == limit);

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker on the controller lamps: decodes the phase, checks one-hot,
// ordering and phase durations, and counts completed checked rounds.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int RED_CYCLES    = 11,
    parameter int GREEN_CYCLES  = 16,
    parameter int YELLOW_CYCLES = 6,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clear,
    output logic [1:0] phase,
    output logic       locked,
    output logic       err_onehot,
    output logic       err_order,
    output logic       err_duration,
    output logic [2:0] err_sticky,
    output logic [7:0] round_count
);

    logic [2:0]       lamp;
    logic [2:0]       lamp_q;
    logic [1:0]       cur_ph;
    logic [1:0]       prev_ph;
    logic             change;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] limit;
    logic             eq_limit_plus1;
    mon_state_t       state_q, state_d;
    logic             onehot_d, order_d, duration_d, round_inc;

    function automatic logic [CNT_W-1:0] expected_cycles(input logic [1:0] ph);
        logic [CNT_W-1:0] n;
        case (ph)
            PH_RED:    n = CNT_W'(RED_CYCLES);
            PH_GREEN:  n = CNT_W'(GREEN_CYCLES);
            PH_YELLOW: n = CNT_W'(YELLOW_CYCLES);
            default:   n = '0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign lamp    = {red, yellow, green};
    assign cur_ph  = lamp_to_phase(lamp);
    assign prev_ph = lamp_to_phase(lamp_q);
    assign change  = (lamp != lamp_q);
    assign limit   = expected_cycles(prev_ph);

    traffic_light_run_counter #(
        .CNT_W(CNT_W)
    ) u_run_counter (
        .clk            (clk),
        .rst_n          (rst_n),
        .change         (change),
        .limit          (limit),
        .run            (run),
        .eq_limit_plus1 (eq_limit_plus1)
    );

    always_comb begin
        state_d    = state_q;
        onehot_d   = 1'b0;
        order_d    = 1'b0;
        duration_d = 1'b0;
        round_inc  = 1'b0;
        if (change) begin
            state_d = MON_ACQUIRE;
            if (prev_ph != PH_NONE && cur_ph == PH_NONE) begin
                onehot_d = 1'b1;
            end else if (prev_ph != PH_NONE && cur_ph != PH_NONE) begin
                if (cur_ph == next_phase(prev_ph)) begin
                    state_d = MON_TRACK;
                    // Only a phase that was itself entered in order has a trustworthy length.
                    if (state_q == MON_TRACK) begin
                        duration_d = (run < limit);
                        round_inc  = (prev_ph == PH_YELLOW);
                    end
                end else begin
                    order_d = 1'b1;
                end
            end
        end else if (state_q == MON_TRACK && eq_limit_plus1) begin
            duration_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lamp_q       <= 3'b000;
            state_q      <= MON_ACQUIRE;
            phase        <= PH_NONE;
            err_onehot   <= 1'b0;
            err_order    <= 1'b0;
            err_duration <= 1'b0;
            err_sticky   <= 3'b000;
            round_count  <= 8'd0;
        end else begin
            lamp_q       <= lamp;
            state_q      <= state_d;
            phase        <= cur_ph;
            err_onehot   <= onehot_d;
            err_order    <= order_d;
            err_duration <= duration_d;
            // A new error in the clearing cycle must survive the clear.
            err_sticky   <= (clear ? 3'b000 : err_sticky) | {duration_d, order_d, onehot_d};
            if (clear) begin
                round_count <= 8'd0;
            end else if (round_inc) begin
                round_count <= sat_inc8(round_count);
            end
        end
    end

    assign locked = (state_q == MON_TRACK);

endmodule
